// File: rtl/uart_rx_if.sv
// Serial line and received-byte signals of the RS-232 receiver.
// master is the receiver side, slave is whoever drives the line and consumes bytes.
interface uart_rx_if;
   logic       RS232_rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       rx_busy;

   modport master (input RS232_rx, output rx_data, rx_valid, frame_err, rx_busy);
   modport slave  (output RS232_rx, input rx_data, rx_valid, frame_err, rx_busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 RS-232 receiver: synchronised input, start-bit validation, 3-sample
// mid-bit majority vote, stop-bit check with valid / frame-error strobes.
module uart_rx #(
   parameter int unsigned BAUD_END = 433,
   parameter int unsigned BAUD_MID = BAUD_END / 2
) (
   input  logic      sclk,
   input  logic      reset,
   uart_rx_if.master rx
);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [8:0] C_END  = 9'(BAUD_END);
   localparam logic [8:0] C_MID  = 9'(BAUD_MID);
   localparam logic [8:0] C_PRE  = C_MID - 9'd1;
   localparam logic [8:0] C_VOTE = C_MID + 9'd1;

   state_t     r_state, w_state_nxt;
   logic       r_rx_m, r_rx_s, r_rx_d;
   logic       r_smp_a, r_smp_b;
   logic [8:0] r_baud_cnt, w_baud_nxt;
   logic [2:0] r_bit_cnt, w_bit_nxt;
   logic [7:0] r_shift, w_shift_nxt;
   logic [7:0] r_data, w_data_nxt;
   logic       r_valid, w_valid_nxt;
   logic       r_ferr, w_ferr_nxt;

   logic       w_fall, w_vote, w_end, w_major;
   logic [8:0] w_baud_inc;

   // Flops reset to 0, so a line held low through reset never looks like a fall.
   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         r_rx_m <= 1'b0;
         r_rx_s <= 1'b0;
         r_rx_d <= 1'b0;
      end else begin
         r_rx_m <= rx.RS232_rx;
         r_rx_s <= r_rx_m;
         r_rx_d <= r_rx_s;
      end
   end

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         r_smp_a <= 1'b0;
         r_smp_b <= 1'b0;
      end else begin
         if (r_baud_cnt == C_PRE) r_smp_a <= r_rx_s;
         if (r_baud_cnt == C_MID) r_smp_b <= r_rx_s;
      end
   end

   assign w_fall     = r_rx_d & ~r_rx_s;
   assign w_vote     = (r_baud_cnt == C_VOTE);
   assign w_end      = (r_baud_cnt == C_END);
   assign w_baud_inc = w_end ? '0 : r_baud_cnt + 9'd1;
   assign w_major    = (r_smp_a & r_smp_b) | (r_smp_a & r_rx_s) | (r_smp_b & r_rx_s);

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_ferr     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_baud_cnt <= w_baud_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_shift    <= w_shift_nxt;
         r_data     <= w_data_nxt;
         r_valid    <= w_valid_nxt;
         r_ferr     <= w_ferr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_shift_nxt = r_shift;
      w_data_nxt  = r_data;
      w_valid_nxt = 1'b0;
      w_ferr_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            w_baud_nxt = '0;
            if (w_fall) w_state_nxt = START;
         end
         START: begin
            w_baud_nxt = w_baud_inc;
            if (w_vote && w_major) begin
               w_state_nxt = IDLE;
               w_baud_nxt  = '0;
            end else if (w_end) begin
               w_state_nxt = DATA;
               w_bit_nxt   = '0;
            end
         end
         DATA: begin
            w_baud_nxt = w_baud_inc;
            if (w_vote) w_shift_nxt = {w_major, r_shift[7:1]};
            if (w_end) begin
               if (r_bit_cnt == 3'd7) w_state_nxt = STOP;
               else                   w_bit_nxt   = r_bit_cnt + 3'd1;
            end
         end
         STOP: begin
            w_baud_nxt = w_baud_inc;
            // Decide at mid-stop and return to IDLE so the next start bit is never missed.
            if (w_vote) begin
               w_state_nxt = IDLE;
               w_baud_nxt  = '0;
               if (w_major) begin
                  w_data_nxt  = r_shift;
                  w_valid_nxt = 1'b1;
               end else begin
                  w_ferr_nxt  = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign rx.rx_data   = r_data;
   assign rx.rx_valid  = r_valid;
   assign rx.frame_err = r_ferr;
   assign rx.rx_busy   = (r_state != IDLE);
endmodule
